// File: rtl/div_sched.sv
// div_sched: round-robin scheduler sharing one clock divider between two requesters.
//
// A granted requester has the divider programmed to its ratio and held in clear for
// CLR_CYC cycles, then the divider runs until npulse rising edges of div_q have been
// seen, and a one-cycle done pulse is returned. Illegal grants (ratio < 2 or
// npulse == 0) complete immediately with err and never release the divider clear.
//
// Ports:
//   clk               system clock, rising edge
//   clear_n           synchronous active-low reset
//   req[1:0]          level request per requester, held until done or abort
//   ratio0/ratio1     divide ratio per requester, sampled at grant
//   npulse0/npulse1   div_q rising edges to run per requester, sampled at grant
//   gnt[1:0]          registered one-hot grant
//   done[1:0]         one-cycle completion pulse for the granted requester
//   err               high with done when the grant was illegal
//   busy              high in any state other than idle
//   div_clear         divider clear (active-high)
//   div[2:0]          divider ratio
//   div_q             divider output, synchronous to clk
module div_sched #(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned CLR_CYC = 2
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic [1:0]       req,
    input  logic [2:0]       ratio0,
    input  logic [2:0]       ratio1,
    input  logic [CNT_W-1:0] npulse0,
    input  logic [CNT_W-1:0] npulse1,
    output logic [1:0]       gnt,
    output logic [1:0]       done,
    output logic             err,
    output logic             busy,
    output logic             div_clear,
    output logic [2:0]       div,
    input  logic             div_q
);

    localparam int unsigned CLR_W = $clog2(CLR_CYC + 1);

    typedef enum logic [1:0] {StIdle, StClr, StRun, StDone} state_e;

    state_e             state_q, state_d;
    logic [1:0]         gnt_q, gnt_d;
    logic [1:0]         done_q, done_d;
    logic               err_q, err_d;
    logic               busy_q, busy_d;
    logic               div_clear_q, div_clear_d;
    logic [2:0]         div_val_q, div_val_d;
    logic               sel_q, sel_d;
    logic               rr_q, rr_d;
    logic               bad_q, bad_d;
    logic               qd_q, qd_d;
    logic [CLR_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   npulse_q, npulse_d;

    logic               pick;
    logic [2:0]         pick_ratio;
    logic [CNT_W-1:0]   pick_np;
    logic               edge_det;
    logic               last_edge;

    always_comb begin
        pick       = req[rr_q] ? rr_q : ~rr_q;
        pick_ratio = pick ? ratio1 : ratio0;
        pick_np    = pick ? npulse1 : npulse0;
        edge_det   = div_q & ~qd_q;
        // npulse_q >= 1 once running, so the subtraction cannot underflow and the
        // counter stops at npulse_q without ever wrapping.
        last_edge  = (cnt_q == npulse_q - CNT_W'(1));
    end

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        done_d      = 2'b00;
        err_d       = 1'b0;
        div_clear_d = div_clear_q;
        div_val_d   = div_val_q;
        sel_d       = sel_q;
        rr_d        = rr_q;
        bad_d       = bad_q;
        clr_cnt_d   = clr_cnt_q;
        cnt_d       = cnt_q;
        npulse_d    = npulse_q;
        // Held low while the divider is in clear so a q already high at run entry
        // is seen as an edge.
        qd_d        = div_clear_q ? 1'b0 : div_q;

        unique case (state_q)
            StIdle: begin
                div_clear_d = 1'b1;
                if (req != 2'b00) begin
                    sel_d     = pick;
                    gnt_d     = pick ? 2'b10 : 2'b01;
                    div_val_d = pick_ratio;
                    npulse_d  = pick_np;
                    bad_d     = (pick_ratio < 3'd2) || (pick_np == '0);
                    clr_cnt_d = CLR_W'(1);
                    cnt_d     = '0;
                    state_d   = StClr;
                end
            end
            StClr: begin
                if (!req[sel_q]) begin
                    state_d     = StIdle;
                    gnt_d       = 2'b00;
                    div_clear_d = 1'b1;
                    rr_d        = ~sel_q;
                end else if (bad_q) begin
                    // Illegal grant completes one cycle after the grant, clear kept high.
                    state_d = StDone;
                    done_d  = gnt_q;
                    err_d   = 1'b1;
                end else if (clr_cnt_q == CLR_W'(CLR_CYC)) begin
                    state_d     = StRun;
                    div_clear_d = 1'b0;
                end else begin
                    clr_cnt_d = clr_cnt_q + CLR_W'(1);
                end
            end
            StRun: begin
                if (!req[sel_q]) begin
                    state_d     = StIdle;
                    gnt_d       = 2'b00;
                    div_clear_d = 1'b1;
                    rr_d        = ~sel_q;
                end else if (edge_det) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (last_edge) begin
                        state_d     = StDone;
                        done_d      = gnt_q;
                        div_clear_d = 1'b1;
                    end
                end
            end
            StDone: begin
                state_d     = StIdle;
                gnt_d       = 2'b00;
                div_clear_d = 1'b1;
                rr_d        = ~sel_q;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            state_q     <= StIdle;
            gnt_q       <= 2'b00;
            done_q      <= 2'b00;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            div_clear_q <= 1'b1;
            div_val_q   <= 3'b010;
            sel_q       <= 1'b0;
            rr_q        <= 1'b0;
            bad_q       <= 1'b0;
            qd_q        <= 1'b0;
            clr_cnt_q   <= '0;
            cnt_q       <= '0;
            npulse_q    <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            div_clear_q <= div_clear_d;
            div_val_q   <= div_val_d;
            sel_q       <= sel_d;
            rr_q        <= rr_d;
            bad_q       <= bad_d;
            qd_q        <= qd_d;
            clr_cnt_q   <= clr_cnt_d;
            cnt_q       <= cnt_d;
            npulse_q    <= npulse_d;
        end
    end

    assign gnt       = gnt_q;
    assign done      = done_q;
    assign err       = err_q;
    assign busy      = busy_q;
    assign div_clear = div_clear_q;
    assign div       = div_val_q;

endmodule

// File: tb/tb_div_sched.sv
// Testbench for div_sched: a behavioural divider drives div_q, expected completions are
// queued when a request is launched and compared by a monitor when done pulses.
module tb_div_sched;

    localparam int unsigned CNT_W = 8;

    logic             clk = 1'b0;
    logic             clear_n;
    logic [1:0]       req;
    logic [2:0]       ratio0, ratio1;
    logic [CNT_W-1:0] npulse0, npulse1;
    logic [1:0]       gnt, done;
    logic             err, busy, div_clear;
    logic [2:0]       div;
    logic             div_q = 1'b0;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        logic [1:0] id;
        logic       err;
        int         np;
    } exp_t;

    exp_t sb[$];

    div_sched #(.CNT_W(CNT_W), .CLR_CYC(2)) dut (
        .clk       (clk),
        .clear_n   (clear_n),
        .req       (req),
        .ratio0    (ratio0),
        .ratio1    (ratio1),
        .npulse0   (npulse0),
        .npulse1   (npulse1),
        .gnt       (gnt),
        .done      (done),
        .err       (err),
        .busy      (busy),
        .div_clear (div_clear),
        .div       (div),
        .div_q     (div_q)
    );

    always #5 clk = ~clk;

    // Divider model: one-cycle q pulse every div cycles, held low in clear.
    int dcnt = 0;
    always @(posedge clk) begin
        if (div_clear === 1'b1) begin
            dcnt  <= 0;
            div_q <= 1'b0;
        end else if (dcnt >= int'(div) - 1) begin
            dcnt  <= 0;
            div_q <= 1'b1;
        end else begin
            dcnt  <= dcnt + 1;
            div_q <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Monitor: counts div_q rises while the divider runs and scores each done pulse.
    int   rises = 0;
    int   since = 0;
    logic prevq = 1'b0;
    logic prev_done = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        since++;
        if (gnt == 2'b00) begin
            rises = 0;
        end else if (div_clear == 1'b0 && div_q && !prevq) begin
            rises++;
            since = 0;
        end
        prevq = (div_clear == 1'b1) ? 1'b0 : div_q;
        if (err == 1'b1 && done == 2'b00) check("err_without_done", 32'(err), 0);
        if (done != 2'b00 && !$isunknown(done)) begin
            check("done_one_cycle", 32'(prev_done), 0);
            if (sb.size() == 0) begin
                check("spurious_done", 32'(done), 0);
            end else begin
                e = sb.pop_front();
                check("done_id", 32'(done), 32'(e.id));
                check("done_err", 32'(err), 32'(e.err));
                if (e.err) begin
                    check("illegal_no_run", 32'(rises), 0);
                end else begin
                    check("pulse_count", 32'(rises), 32'(e.np));
                    check("done_latency", 32'(since), 1);
                end
            end
        end
        prev_done = (done != 2'b00 && !$isunknown(done));
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_gnt(input logic [1:0] exp);
        int n = 0;
        while (gnt == 2'b00 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("gnt", 32'(gnt), 32'(exp));
    endtask

    task automatic wait_done(input logic [1:0] req_after);
        int n = 0;
        while (done == 2'b00 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", 32'(done != 2'b00), 1);
        req = req_after;
        @(negedge clk);
        check("gnt_drop", 32'(gnt), 0);
        check("done_drop", 32'(done), 0);
        check("clear_after", 32'(div_clear), 1);
    endtask

    task automatic wait_run();
        int n = 0;
        while (div_clear == 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("run_entry", 32'(div_clear), 0);
    endtask

    // {gnt, done, err, busy, div_clear, div}
    localparam logic [9:0] RstVec = 10'b00_00_0_0_1_010;

    initial begin
        clear_n = 1'b0;
        req     = 2'b11;
        ratio0  = 3'd3;
        ratio1  = 3'd3;
        npulse0 = 8'd1;
        npulse1 = 8'd1;

        // Reset held with both requests pending.
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("reset_outputs", 32'({gnt, done, err, busy, div_clear, div}), 32'(RstVec));
        end
        req     = 2'b00;
        clear_n = 1'b1;
        tick(2);
        check("idle_after_release", 32'({gnt, busy}), 0);

        // Single run on requester 0.
        ratio0  = 3'd3;
        npulse0 = 8'd4;
        sb.push_back('{2'b01, 1'b0, 4});
        req = 2'b01;
        wait_gnt(2'b01);
        check("single_div", 32'(div), 3);
        check("single_busy", 32'(busy), 1);
        check("single_clear0", 32'(div_clear), 1);
        ratio0  = 3'd7;   // post-grant changes must be ignored
        npulse0 = 8'd1;
        tick(1);
        check("single_clear1", 32'(div_clear), 1);
        tick(1);
        check("single_clear_fall", 32'(div_clear), 0);
        check("single_div_held", 32'(div), 3);
        wait_done(2'b00);

        // Illegal grant: ratio below 2.
        ratio1  = 3'd1;
        npulse1 = 8'd5;
        sb.push_back('{2'b10, 1'b1, 0});
        req = 2'b10;
        wait_gnt(2'b10);
        check("bad_ratio_div", 32'(div), 1);
        check("bad_ratio_clear", 32'(div_clear), 1);
        tick(1);
        check("bad_ratio_err", 32'({done, err, div_clear}), 32'({2'b10, 1'b1, 1'b1}));
        wait_done(2'b00);

        // Illegal grant: zero pulses.
        ratio1  = 3'd4;
        npulse1 = 8'd0;
        sb.push_back('{2'b10, 1'b1, 0});
        req = 2'b10;
        wait_gnt(2'b10);
        check("bad_np_clear", 32'(div_clear), 1);
        tick(1);
        check("bad_np_err", 32'({done, err, div_clear}), 32'({2'b10, 1'b1, 1'b1}));
        wait_done(2'b00);

        // Both requesting continuously: grants alternate 0,1,0,1.
        ratio0  = 3'd2;
        npulse0 = 8'd2;
        ratio1  = 3'd5;
        npulse1 = 8'd3;
        req     = 2'b11;
        for (int i = 0; i < 4; i++) begin
            logic [1:0] id;
            id = (i % 2 == 0) ? 2'b01 : 2'b10;
            sb.push_back('{id, 1'b0, (id == 2'b01) ? 2 : 3});
            wait_gnt(id);
            check("arb_div", 32'(div), (id == 2'b01) ? 2 : 5);
            wait_done((i == 3) ? 2'b00 : 2'b11);
        end

        // Maximum pulse count: counter must reach 255 without wrapping.
        ratio0  = 3'd2;
        npulse0 = 8'hff;
        sb.push_back('{2'b01, 1'b0, 255});
        req = 2'b01;
        wait_gnt(2'b01);
        wait_done(2'b00);

        // Abort requester 0 mid-run while requester 1 waits.
        ratio0  = 3'd3;
        npulse0 = 8'd6;
        ratio1  = 3'd5;
        npulse1 = 8'd3;
        req = 2'b01;
        wait_gnt(2'b01);
        wait_run();
        tick(2);
        req = 2'b10;
        tick(1);
        check("abort_gnt", 32'(gnt), 0);
        check("abort_done", 32'(done), 0);
        check("abort_clear", 32'(div_clear), 1);
        sb.push_back('{2'b10, 1'b0, 3});
        wait_gnt(2'b10);
        check("after_abort_div", 32'(div), 5);
        wait_done(2'b00);

        // Reset during run: outputs return to reset values, no done issued.
        ratio0  = 3'd2;
        npulse0 = 8'd50;
        req = 2'b01;
        wait_gnt(2'b01);
        wait_run();
        tick(3);
        clear_n = 1'b0;
        tick(1);
        check("midrun_reset", 32'({gnt, done, err, busy, div_clear, div}), 32'(RstVec));
        req     = 2'b00;
        clear_n = 1'b1;
        tick(4);
        check("post_reset_idle", 32'({gnt, done, busy}), 0);
        check("scoreboard_empty", 32'(sb.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
